// File: rtl/cam_types.sv
// Shared key/value types for the CAM request queue and its CAM port.
package cam_types;

  typedef logic [7:0] key_t;
  typedef logic [7:0] val_t;

endpackage

// File: rtl/cam_req_queue.sv
// In-order request FIFO in front of a CAM. Writes issue one per cycle; a read
// blocks further issue until its response has been handed downstream.
module cam_req_queue
  import cam_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  // upstream requests
  input  logic req_valid_i,
  output logic req_ready_o,
  input  logic req_rw_n_i,
  input  key_t req_key_i,
  input  val_t req_val_i,
  // CAM command / return
  output logic cam_valid_o,
  output logic cam_rw_n_o,
  output key_t cam_key_o,
  output val_t cam_val_o,
  input  val_t cam_val_i,
  input  logic cam_valid_i,
  // downstream read response
  output logic rsp_valid_o,
  input  logic rsp_ready_i,
  output logic rsp_hit_o,
  output val_t rsp_val_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef struct packed {
    logic rw_n;
    key_t key;
    val_t val;
  } entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRsp,
    StHoldRsp
  } state_e;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic            rsp_hit_q, rsp_hit_d;
  val_t            rsp_val_q, rsp_val_d;

  logic   push;
  logic   pop;
  entry_t head;

  assign head = mem_q[rd_ptr_q];

  // Ready depends only on the registered count, so a simultaneous pop never frees a slot.
  assign req_ready_o = (count_q != FullCnt) & ~reset_i;
  assign push        = req_valid_i & req_ready_o;
  // Issue only from stored entries: nothing pushed this cycle can be popped this cycle.
  assign pop         = (state_q == StIdle) & (count_q != '0) & ~reset_i;

  // FIFO next-state: storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rw_n: req_rw_n_i, key: req_key_i, val: req_val_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FSM next-state and response capture.
  always_comb begin
    state_d   = state_q;
    rsp_hit_d = rsp_hit_q;
    rsp_val_d = rsp_val_q;
    case (state_q)
      StIdle: begin
        if (pop && head.rw_n) begin
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        rsp_hit_d = cam_valid_i;
        rsp_val_d = cam_valid_i ? cam_val_i : '0;
        state_d   = StHoldRsp;
      end
      StHoldRsp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: command fields zero unless strobing; everything forced low during reset.
  always_comb begin
    cam_valid_o = 1'b0;
    cam_rw_n_o  = 1'b0;
    cam_key_o   = '0;
    cam_val_o   = '0;
    rsp_valid_o = 1'b0;
    rsp_hit_o   = 1'b0;
    rsp_val_o   = '0;
    if (pop) begin
      cam_valid_o = 1'b1;
      cam_rw_n_o  = head.rw_n;
      cam_key_o   = head.key;
      cam_val_o   = head.val;
    end
    if ((state_q == StHoldRsp) && !reset_i) begin
      rsp_valid_o = 1'b1;
      rsp_hit_o   = rsp_hit_q;
      rsp_val_o   = rsp_val_q;
    end
  end

  // Control state with synchronous reset; a reset drops queued entries and held responses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      rsp_hit_q <= 1'b0;
      rsp_val_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_val_q <= rsp_val_d;
    end
  end

  // Entry storage; contents are only observed when count marks them valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
